// File: rtl/mac_operand_loader.sv
// mac_operand_loader: assembles a byte stream into one registered operand set
// (A0..A3, B2) for the multiply block. The packet mode, sampled with the first
// byte, selects how many bytes arrive and which lanes they fill. The complete
// set is presented on out_valid and held until the consumer takes it.
//
// Handshake semantics (both sides): a transfer happens on a rising clock edge
// where valid & ready & en are all high. Valid never depends on ready.
// in_ready is high only while collecting bytes. out_valid is high only while
// a complete set is held.

`ifndef MAC_MIN_WIDTH
`define MAC_MIN_WIDTH 8
`endif
`ifndef MAC_CONF_WIDTH
`define MAC_CONF_WIDTH 3
`endif
`ifndef MAC_SINGLE
`define MAC_SINGLE 2'b00
`endif
`ifndef MAC_DUAL
`define MAC_DUAL 2'b01
`endif
`ifndef MAC_QUAD
`define MAC_QUAD 2'b10
`endif

module mac_operand_loader #(
  parameter int MIN_WIDTH  = `MAC_MIN_WIDTH,
  parameter int CONF_WIDTH = `MAC_CONF_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [CONF_WIDTH-1:0] cfg,
  input  logic                  in_valid,
  input  logic [MIN_WIDTH-1:0]  in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [MIN_WIDTH-1:0]  out_A0,
  output logic [MIN_WIDTH-1:0]  out_A1,
  output logic [MIN_WIDTH-1:0]  out_A2,
  output logic [MIN_WIDTH-1:0]  out_A3,
  output logic [MIN_WIDTH-1:0]  out_B2,
  output logic [1:0]            out_cfg,
  output logic                  cfg_err,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Lane identifiers, also the index into lane_q.
  localparam logic [2:0] LANE_A0 = 3'd0;
  localparam logic [2:0] LANE_A1 = 3'd1;
  localparam logic [2:0] LANE_A2 = 3'd2;
  localparam logic [2:0] LANE_A3 = 3'd3;
  localparam logic [2:0] LANE_B2 = 3'd4;

  state_t               state;
  logic [2:0]           cnt;
  logic [MIN_WIDTH-1:0] lane_q [5];
  logic [1:0]           cfg_mode;
  logic [2:0]           wr_lane;
  logic                 xfer;
  logic                 unused_cfg_bits;

  // Lane written by byte number idx of a packet in the given mode.
  function automatic logic [2:0] lane_sel(input logic [1:0] mode, input logic [2:0] idx);
    logic [2:0] l;
    l = LANE_B2;
    case (mode)
      `MAC_SINGLE: l = (idx == 3'd0) ? LANE_A2 : LANE_B2;
      `MAC_DUAL: begin
        case (idx)
          3'd0:    l = LANE_A2;
          3'd1:    l = LANE_A3;
          default: l = LANE_B2;
        endcase
      end
      default: begin
        case (idx)
          3'd0:    l = LANE_A0;
          3'd1:    l = LANE_A1;
          3'd2:    l = LANE_A2;
          3'd3:    l = LANE_A3;
          default: l = LANE_B2;
        endcase
      end
    endcase
    return l;
  endfunction

  // Number of bytes in a packet of the given mode.
  function automatic logic [2:0] pkt_len(input logic [1:0] mode);
    logic [2:0] n;
    case (mode)
      `MAC_SINGLE: n = 3'd2;
      `MAC_DUAL:   n = 3'd3;
      default:     n = 3'd5;
    endcase
    return n;
  endfunction

  // Only cfg[1:0] is decoded; upper bits are intentionally ignored.
  assign cfg_mode        = cfg[1:0];
  assign unused_cfg_bits = ^cfg;

  // Accept bytes only while collecting, enabled and out of reset.
  assign in_ready = en & ~rst & (state != HOLD);
  assign xfer     = in_valid & in_ready;

  // First byte follows the incoming mode; later bytes follow the latched mode.
  assign wr_lane = (state == IDLE) ? lane_sel(cfg_mode, 3'd0) : lane_sel(out_cfg, cnt);

  assign out_A0    = lane_q[LANE_A0];
  assign out_A1    = lane_q[LANE_A1];
  assign out_A2    = lane_q[LANE_A2];
  assign out_A3    = lane_q[LANE_A3];
  assign out_B2    = lane_q[LANE_B2];
  assign dbg_state = state;

  // Packet FSM: byte collection, operand hold and consumer handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 3'd0;
      out_cfg   <= 2'b00;
      out_valid <= 1'b0;
      cfg_err   <= 1'b0;
      for (int i = 0; i < 5; i++) lane_q[i] <= '0;
    end else if (en) begin
      cfg_err <= 1'b0;
      case (state)
        IDLE: begin
          if (xfer) begin
            if (cfg_mode == 2'b11) begin
              // Illegal mode: drop the byte, keep lanes, flag for one cycle.
              cfg_err <= 1'b1;
            end else begin
              // New packet: stale lanes from a wider mode must read 0.
              out_cfg <= cfg_mode;
              for (int i = 0; i < 5; i++) lane_q[i] <= '0;
              lane_q[wr_lane] <= in_data;
              cnt             <= 3'd1;
              state           <= LOAD;
            end
          end
        end
        LOAD: begin
          if (xfer) begin
            lane_q[wr_lane] <= in_data;
            if (cnt + 3'd1 == pkt_len(out_cfg)) begin
              cnt       <= 3'd0;
              state     <= HOLD;
              out_valid <= 1'b1;
            end else begin
              cnt <= cnt + 3'd1;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/mac_operand_loader.md
MAC_OPERAND_LOADER -- requirements
Module: mac_operand_loader

Interface
REQ-001 Parameter MIN_WIDTH, default `MAC_MIN_WIDTH (8): width of one operand lane and of the input byte.
REQ-002 Parameter CONF_WIDTH, default `MAC_CONF_WIDTH (3): cfg width; only cfg[1:0] is decoded.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 en  input  1  global enable; low freezes the block.
REQ-006 cfg  input  CONF_WIDTH  packet mode, sampled with the first byte: `MAC_SINGLE=00, `MAC_DUAL=01, `MAC_QUAD=10, 11 illegal.
REQ-007 in_valid  input  1  byte-stream valid.
REQ-008 in_data  input  MIN_WIDTH  byte-stream data.
REQ-009 in_ready  output  1  byte-stream ready.
REQ-010 out_valid  output  1  operand set valid.
REQ-011 out_ready  input  1  consumer (multiply block) ready.
REQ-012 out_A0, out_A1, out_A2, out_A3, out_B2  output  MIN_WIDTH each  registered operand lanes.
REQ-013 out_cfg  output  2  latched cfg[1:0] of the presented set.
REQ-014 cfg_err  output  1  one-cycle pulse on illegal cfg.

Function
REQ-015 FSM states SHALL be IDLE, LOAD, HOLD.
REQ-016 A byte transfer SHALL occur on a rising edge with in_valid & in_ready & en.
REQ-017 Packet byte order SHALL be: SINGLE A2,B2 (2 bytes); DUAL A2,A3,B2 (3); QUAD A0,A1,A2,A3,B2 (5).
REQ-018 in_ready SHALL equal en & (state is IDLE or LOAD); in_ready SHALL be 0 in HOLD.
REQ-019 IDLE, transfer with cfg[1:0] legal: latch cfg[1:0] into out_cfg, clear all five lanes to 0, write the byte into the first lane of the order, byte counter = 1, go LOAD.
REQ-020 IDLE, transfer with cfg[1:0]=11: byte discarded, lanes unchanged, cfg_err high for exactly the next cycle, stay IDLE.
REQ-021 LOAD: each transfer writes the byte into the lane indexed by the counter and increments it; cfg is ignored.
REQ-022 LOAD: the transfer of the last byte of the packet SHALL move the FSM to HOLD; out_valid SHALL be 1 in the cycle immediately following that edge (latency 1).
REQ-023 Lanes not used by the latched mode SHALL read 0 while out_valid is 1.
REQ-024 HOLD: out_valid=1; all out_* lanes and out_cfg SHALL remain stable until handshake.
REQ-025 HOLD with out_ready & en at an edge: go IDLE; out_valid 0 from the next cycle; lanes retain values.
REQ-026 out_valid SHALL be 1 exactly when state is HOLD.
REQ-027 en low: no state, counter, lane or cfg_err change; in_ready 0; out_ready ignored; out_valid holds.
REQ-028 in_valid low in LOAD SHALL stall with no timeout; partial packets are kept.
REQ-029 Minimum packet period SHALL be byte count + 1 cycles (e.g. QUAD 6 cycles).

Reset
REQ-030 rst high SHALL immediately force IDLE, counter 0, all lanes 0, out_cfg 0, out_valid 0, cfg_err 0, in_ready 0.
REQ-031 rst asserted mid-LOAD or in HOLD SHALL discard the packet; the first transfer after release is treated as a new first byte.
REQ-032 After rst deasserts, in_ready SHALL equal en from the first cycle.

Verification
REQ-033 SINGLE: cfg=00, bytes 0x12,0x34 back-to-back, out_ready=1 -> out_valid 1 cycle later, A2=0x12, B2=0x34, A0=A1=A3=0, out_cfg=00; handshake in one cycle.
REQ-034 QUAD: cfg=10, bytes 0x01,0x02,0x03,0x04,0xFF, out_ready=0 for 3 cycles then 1 -> A0..A3=01,02,03,04, B2=FF held stable across all 4 valid cycles; in_ready 0 throughout HOLD.
REQ-035 DUAL after QUAD: QUAD packet consumed, then cfg=01 bytes 0xAA,0xBB,0xCC -> A2=AA, A3=BB, B2=CC, A0=A1=0 (stale lanes cleared).
REQ-036 Illegal cfg: cfg=11 with byte 0x55 -> cfg_err pulses 1 cycle, out_valid stays 0, next cfg=00 packet 0x07,0x08 loads normally.
REQ-037 Stall/enable: QUAD with in_valid gaps and en low for 2 cycles mid-LOAD -> no lane change while en low; final set identical to the unstalled case.
REQ-038 Reset mid-operation: rst after 3 QUAD bytes -> all outputs 0 immediately; following SINGLE 0x21,0x43 -> A2=21, B2=43.
